dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory responder for the AddrMode command issued by the core's control unit.
- Accepts one load or store request per handshake and performs byte, half or word access on an internal word-wide, little-endian RAM.
- Returns sign- or zero-extended load data, flags misaligned accesses, and drives a busy/stall indication back to the datapath.
- Sits between the ALU result (address), regfile rd2 (store data) and the result mux.

Parameters:
DATA_WIDTH, 32, data and address width
DEPTH_WORDS, 1024, number of 32-bit RAM words; must be a power of 2
INIT_FILE, "", hex image loaded with $readmemh at time 0 when non-empty

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
AddrMode  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
addr  in  DATA_WIDTH  byte address
wdata  in  DATA_WIDTH  store data; the low byte, half or word is used
resp_valid  out  1  one-cycle pulse: access complete
rdata  out  DATA_WIDTH  extended load data, valid while resp_valid is high
err  out  1  misaligned flag, valid while resp_valid is high
busy  out  1  equals !req_ready; the pipeline stalls on it

Behaviour:
- Reset: one clock, synchronous, active-high. State = IDLE, req_ready=1, busy=0, resp_valid=0, rdata=0, err=0. RAM contents are not affected by reset.
- State machine has three states:
  - IDLE: req_ready=1. On req_valid=1, latch AddrMode, addr and wdata, then go to ACCESS.
  - ACCESS: one cycle. On the edge leaving ACCESS:
    - a store commits its byte lanes;
    - a load registers the RAM word.
    - Then go to RESP.
  - RESP: one cycle. resp_valid=1 with rdata and err valid, then return to IDLE.
- Latency: if the request is accepted at edge E0, resp_valid is high in the cycle after E1 and clears at E2. Throughput is one request per 3 cycles. req_ready=0 throughout ACCESS and RESP, and requests presented then are ignored.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Byte lane is addr[1:0], little-endian: lane 0 is bits [7:0].
- Store byte enables:
  - SB writes lane addr[1:0] with wdata[7:0];
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - SW writes all four lanes. Unenabled lanes keep their old value.
- Load extension:
  - LB/LH sign-extend bit 7/15 of the selected byte/half;
  - LBU/LHU zero-extend;
  - LW returns the word unchanged.
- Misaligned accesses are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=00. With DMEM_ERR_EN defined:
  - no RAM write occurs;
  - rdata=0 and err=1 in RESP;
  - the FSM timing is unchanged.
- rdata and err return to 0 in every cycle outside RESP.
- Reset mid-operation: rst dominates. If rst is high at the edge leaving ACCESS, the store is not committed and the FSM returns to IDLE with no resp_valid pulse.
- Store then load to the same address in consecutive requests returns the newly stored data, because the commit precedes the next accept.

Optional Feature:
DMEM_ERR_EN
- Defined: misaligned detection as above; err is driven.
- Undefined:
  - err is tied 0;
  - misaligned addresses are force-aligned (addr[0] cleared for half accesses, addr[1:0] cleared for word accesses) and the access proceeds normally.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> rdata=0xDEADBEEF, err=0, resp_valid exactly 2 cycles after each accept.
- SB addr=0x21 wdata=0x000000AA over word 0x11223344 -> LW 0x20 returns 0x1122AA44; LB 0x21 returns 0xFFFFFFAA; LBU 0x21 returns 0x000000AA.
- SH addr=0x32 wdata=0x8001 over zeroed word -> LH 0x32 returns 0xFFFF8001; LHU 0x32 returns 0x00008001; LW 0x30 returns 0x80010000.
- With DMEM_ERR_EN: SW addr=0x41 -> err=1, rdata=0, word 0x40 unchanged. Without DMEM_ERR_EN: the same SW writes word 0x40 and err=0.
- Hold req_valid high continuously with alternating requests -> accepts only in IDLE, one per 3 cycles, busy=1 in ACCESS/RESP; addr=DEPTH_WORDS*4+0x8 aliases to 0x8.
- SW addr=0x50 with rst asserted at the ACCESS exit edge -> no resp_valid pulse, FSM in IDLE; subsequent LW 0x50 returns the prior value.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the core datapath and the dmem_ctrl data-memory responder.
// master = core side, slave = dmem_ctrl.
interface dmem_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            AddrMode;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  busy;

    modport master (
        output req_valid, AddrMode, addr, wdata,
        input  req_ready, resp_valid, rdata, err, busy
    );

    modport slave (
        input  req_valid, AddrMode, addr, wdata,
        output req_ready, resp_valid, rdata, err, busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory responder: byte/half/word loads and stores on a little-endian word RAM, IDLE->ACCESS->RESP.
// Define DMEM_ERR_EN to flag misaligned accesses; otherwise they are force-aligned and err stays 0.
module dmem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = ""
) (
    input  logic     clk,
    input  logic     rst,
    dmem_ctrl_if.slave bus
);
    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_reg;
    logic [2:0]            mode_reg;
    logic [AW+1:0]         addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  req_ready_reg;
    logic                  busy_reg;
    logic                  resp_valid_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [DATA_WIDTH-1:0] rd_word_reg;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[DATA_WIDTH-1:AW+2];

    // Request decode on the latched command
    logic is_store, is_word, is_half, is_byte, mis;
    logic [1:0] lane_sel;
    logic [AW-1:0] word_idx;

    assign is_store = mode_reg[2] & (mode_reg[1] | mode_reg[0]);
    assign is_word  = (mode_reg == 3'b010) || (mode_reg == 3'b111);
    assign is_half  = (mode_reg == 3'b001) || (mode_reg == 3'b100) || (mode_reg == 3'b110);
    assign is_byte  = !is_word && !is_half;
    assign word_idx = addr_reg[AW+1:2];

`ifdef DMEM_ERR_EN
    assign mis      = (is_half & addr_reg[0]) | (is_word & (addr_reg[1:0] != 2'b00));
    assign lane_sel = addr_reg[1:0];
`else
    assign mis      = 1'b0;
    assign lane_sel = is_word ? 2'b00 : (is_half ? {addr_reg[1], 1'b0} : addr_reg[1:0]);
`endif

    // Byte enables and lane-replicated store data
    logic [LANES-1:0]      be;
    logic [DATA_WIDTH-1:0] wlane;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign be[gi] = is_word
                          | (is_half & (lane_sel[1] == LANE[1]))
                          | (is_byte & (lane_sel == LANE));
            assign wlane[gi*8 +: 8] = is_word ? wdata_reg[gi*8 +: 8]
                                    : (is_half ? wdata_reg[(gi%2)*8 +: 8] : wdata_reg[7:0]);
        end
    endgenerate

    // Store commit on the ACCESS exit edge; reset at that edge cancels it
    always_ff @(posedge clk) begin
        if (!rst && state_reg == ACCESS && is_store && !mis) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[word_idx][i*8 +: 8] <= wlane[i*8 +: 8];
            end
        end
    end

    // Registered RAM read, addressed straight from the bus so the word is ready by ACCESS
    always_ff @(posedge clk) begin
        if (state_reg == IDLE) rd_word_reg <= mem[bus.addr[AW+1:2]];
    end

    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign sel_byte = rd_word_reg[{lane_sel, 3'b000} +: 8];
    assign sel_half = rd_word_reg[{lane_sel[1], 4'b0000} +: 16];

    always_comb begin
        load_data = '0;
        case (mode_reg)
            3'b000:  load_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            3'b010:  load_data = rd_word_reg;
            3'b011:  load_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            3'b100:  load_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            resp_valid_reg <= 1'b0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            mode_reg       <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        mode_reg      <= bus.AddrMode;
                        addr_reg      <= bus.addr[AW+1:0];
                        wdata_reg     <= bus.wdata;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_valid_reg <= 1'b1;
                    rdata_reg      <= (mis || is_store) ? '0 : load_data;
                    err_reg        <= mis;
                    state_reg      <= RESP;
                end
                RESP: begin
                    resp_valid_reg <= 1'b0;
                    rdata_reg      <= '0;
                    err_reg        <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.busy       = busy_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.rdata      = rdata_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: per-feature tasks with inline checks and one line per transaction.
module tb_dmem_ctrl;
    localparam int DEPTH_WORDS = 1024;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011;
    localparam logic [2:0] LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;
    localparam logic [31:0] ALIAS_ADDR = DEPTH_WORDS * 4 + 32'h8;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    dmem_ctrl_if #(.DATA_WIDTH(32)) bus ();

    dmem_ctrl #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request, wait (bounded) for resp_valid, return to IDLE
    task automatic do_req(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e, output int lat);
        rd  = '0;
        e   = 1'b0;
        lat = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.AddrMode  = m;
        bus.addr      = a;
        bus.wdata     = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                rd  = bus.rdata;
                e   = bus.err;
                lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        $display("txn mode=%0d addr=%h wdata=%h rdata=%h err=%0b lat=%0d", m, a, wd, rd, e, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.AddrMode  = LW;
        bus.addr      = '0;
        bus.wdata     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", bus.req_ready); end
        $display("txn reset done");
    endtask

    task automatic test_sw_lw;
        logic [31:0] rd; logic e; int lat;
        do_req(SW, 32'h10, 32'hDEADBEEF, rd, e, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", e); end
        do_req(LW, 32'h10, 32'h0, rd, e, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", e); end
        @(negedge clk);
        checks++; if (bus.rdata !== 32'h0 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL idle_clear: rdata=%h resp_valid=%b expected 0/0", bus.rdata, bus.resp_valid);
        end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic e; int lat;
        do_req(SW, 32'h20, 32'h11223344, rd, e, lat);
        do_req(SB, 32'h21, 32'h000000AA, rd, e, lat);
        do_req(LW, 32'h20, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL sb_lw: got %h expected 1122aa44", rd); end
        do_req(LB, 32'h21, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_21: got %h expected ffffffaa", rd); end
        do_req(LBU, 32'h21, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu_21: got %h expected 000000aa", rd); end
        do_req(LB, 32'h23, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lb_23: got %h expected 00000011", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic e; int lat;
        do_req(SW, 32'h30, 32'h0, rd, e, lat);
        do_req(SH, 32'h32, 32'h00008001, rd, e, lat);
        do_req(LH, 32'h32, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_32: got %h expected ffff8001", rd); end
        do_req(LHU, 32'h32, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_32: got %h expected 00008001", rd); end
        do_req(LW, 32'h30, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h80010000) begin errors++; $display("FAIL sh_lw: got %h expected 80010000", rd); end
        do_req(LH, 32'h30, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL lh_30: got %h expected 00000000", rd); end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic e; int lat;
        do_req(SW, 32'h40, 32'h01020304, rd, e, lat);
        do_req(SW, 32'h41, 32'hCAFEF00D, rd, e, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency: got %0d expected 2", lat); end
`ifdef DMEM_ERR_EN
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL mis_sw_err: got %b expected 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_sw_rdata: got %h expected 0", rd); end
        do_req(LW, 32'h40, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL mis_word_kept: got %h expected 01020304", rd); end
        do_req(LH, 32'h43, 32'h0, rd, e, lat);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_lh: err=%b rdata=%h expected 1/0", e, rd); end
`else
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mis_sw_err: got %b expected 0", e); end
        do_req(LW, 32'h40, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_word_aligned: got %h expected cafef00d", rd); end
        do_req(LH, 32'h43, 32'h0, rd, e, lat);
        checks++; if (e !== 1'b0 || rd !== 32'hFFFFCAFE) begin errors++; $display("FAIL mis_lh: err=%b rdata=%h expected 0/ffffcafe", e, rd); end
`endif
    endtask

    // req_valid held high; requests offered while busy are junk stores that must be ignored
    task automatic test_back_to_back;
        logic [31:0] exp_rd;
        int j;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            j = k / 3;
            checks++; if (bus.req_ready !== (k % 3 == 0)) begin errors++; $display("FAIL b2b_ready k=%0d: got %b expected %b", k, bus.req_ready, (k % 3 == 0)); end
            checks++; if (bus.busy !== (k % 3 != 0)) begin errors++; $display("FAIL b2b_busy k=%0d: got %b expected %b", k, bus.busy, (k % 3 != 0)); end
            checks++; if (bus.resp_valid !== (k % 3 == 2)) begin errors++; $display("FAIL b2b_resp k=%0d: got %b expected %b", k, bus.resp_valid, (k % 3 == 2)); end
            if (k % 3 == 2 && j % 2 == 1) begin
                exp_rd = 32'h5A5A0000 + 32'(j - 1);
                checks++; if (bus.rdata !== exp_rd) begin errors++; $display("FAIL b2b_alias_rdata k=%0d: got %h expected %h", k, bus.rdata, exp_rd); end
            end
            bus.req_valid = 1'b1;
            if (k % 3 == 0) begin
                bus.AddrMode = (j % 2 == 0) ? SW : LW;
                bus.addr     = (j % 2 == 0) ? ALIAS_ADDR : 32'h8;
                bus.wdata    = 32'h5A5A0000 + 32'(j);
                $display("txn b2b j=%0d mode=%0d addr=%h wdata=%h", j, bus.AddrMode, bus.addr, bus.wdata);
            end else begin
                bus.AddrMode = SW;
                bus.addr     = 32'h8;
                bus.wdata    = 32'hBAD00000 + 32'(k);
            end
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic e; int lat;
        do_req(SW, 32'h50, 32'h13579BDF, rd, e, lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.AddrMode  = SW;
        bus.addr      = 32'h50;
        bus.wdata     = 32'hFFFFFFFF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_access_busy: got %b expected 1", bus.busy); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_resp c=%0d: got %b expected 0", i, bus.resp_valid); end
        end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", bus.req_ready); end
        $display("txn reset asserted at ACCESS exit for SW addr=00000050");
        do_req(LW, 32'h50, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h13579BDF) begin errors++; $display("FAIL rstmid_kept: got %h expected 13579bdf", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL rstmid_lat: got %0d expected 2", lat); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte();
        test_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
